// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising the I-cache (port 0) and D-cache (port 1)
// write-back and fill requests onto a single main-memory transaction port.
module mem_arbiter #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             p0_write_req,
    input  logic [31:0]      p0_write_addr,
    input  logic [WIDTH-1:0] p0_write_data,
    output logic             p0_write_ack,
    input  logic             p0_read_req,
    input  logic [31:0]      p0_read_addr,
    output logic [WIDTH-1:0] p0_read_data,
    output logic             p0_read_ack,

    input  logic             p1_write_req,
    input  logic [31:0]      p1_write_addr,
    input  logic [WIDTH-1:0] p1_write_data,
    output logic             p1_write_ack,
    input  logic             p1_read_req,
    input  logic [31:0]      p1_read_addr,
    output logic [WIDTH-1:0] p1_read_data,
    output logic             p1_read_ack,

    output logic             mem_req,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t     state, state_next;
    logic       last_grant;
    logic       grant, grant_next;
    logic       load, load_write;
    logic [1:0] pending;
    logic [1:0] read_req;

    logic [31:0]      sel_write_addr;
    logic [31:0]      sel_read_addr;
    logic [WIDTH-1:0] sel_write_data;

    assign read_req = {p1_read_req, p0_read_req};
    assign pending  = {p1_write_req | p1_read_req, p0_write_req | p0_read_req};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        grant_next = grant;
        load       = 1'b0;
        load_write = 1'b0;
        case (state)
            IDLE: begin
                if (pending != 2'b00) begin
                    grant_next = (pending == 2'b11) ? ~last_grant : pending[1];
                    load       = 1'b1;
                    load_write = grant_next ? p1_write_req : p0_write_req;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) state_next = ACK;
            end
            ACK: begin
                // A write-back followed by a pending fill keeps the port locked.
                if (mem_write && read_req[grant]) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sel_write_addr = grant_next ? p1_write_addr : p0_write_addr;
    assign sel_write_data = grant_next ? p1_write_data : p0_write_data;
    assign sel_read_addr  = grant_next ? p1_read_addr  : p0_read_addr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            p0_read_data <= '0;
            p1_read_data <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (state == IDLE && load) last_grant <= grant_next;
            if (load) begin
                mem_write <= load_write;
                if (load_write) begin
                    mem_addr  <= sel_write_addr;
                    mem_wdata <= sel_write_data;
                end else begin
                    mem_addr  <= sel_read_addr;
                end
            end
            if (state == ISSUE && mem_ack && !mem_write) begin
                if (grant) p1_read_data <= mem_rdata;
                else       p0_read_data <= mem_rdata;
            end
        end
    end

    assign mem_req      = (state == ISSUE);
    assign p0_write_ack = (state == ACK) && !grant &&  mem_write;
    assign p0_read_ack  = (state == ACK) && !grant && !mem_write;
    assign p1_write_ack = (state == ACK) &&  grant &&  mem_write;
    assign p1_read_ack  = (state == ACK) &&  grant && !mem_write;

endmodule
